// File: rtl/adder4_acc_ctrl_if.sv
// adder4_acc_ctrl_if: bundle of the three streams around the frame accumulator.
//   in_*    : byte stream into the accumulator (valid/ready, in_last ends a frame)
//   add_*   : operands to / result from the external 8-bit adder
//   out_*   : one frame result per handshake (sum, byte count, saturation flag)
// Modports:
//   master : the accumulator controller side
//   slave  : the environment side (byte source, adder, result consumer)
interface adder4_acc_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_sum;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_count;
    logic       out_sat;

    modport master (
        input  in_valid, in_data, in_last, add_sum, out_ready,
        output in_ready, add_a, add_b, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        output in_valid, in_data, in_last, add_sum, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/adder4_acc_ctrl.sv
// adder4_acc_ctrl: streaming byte accumulator driving an external 8-bit adder.
// Accepts bytes on a valid/ready stream, sums them frame by frame (FRAME_LEN
// bytes, or fewer when in_last marks an early end) and presents one result per
// frame on a valid/ready output. The adder itself lives outside this block.
// Ports:
//   wb_clk_i  : clock, all state on the rising edge
//   wb_rst_i  : asynchronous active-high reset, discards any partial frame
//   bus       : adder4_acc_ctrl_if.master (input stream, adder operands, result)
//   busy      : a frame is being accumulated (ACCUM state)
// Optional feature: define ADDER4_ACC_SAT_EN to saturate the frame sum at 8'hFF
// and report it on out_sat; without it the sum wraps modulo 256 and out_sat is 0.
module adder4_acc_ctrl #(
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    adder4_acc_ctrl_if.master  bus,
    output logic               busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   acc;
    logic [CNT_W-1:0]    cnt;

    logic                in_hold;
    logic                accept;
    logic                handshake;
    logic                first;
    logic [CNT_W-1:0]    cnt_next;
    logic                frame_end;
    logic [DATA_W-1:0]   acc_next;

    assign in_hold   = (state == HOLD);
    assign handshake = in_hold & bus.out_ready;
    assign accept    = bus.in_valid & bus.in_ready;

    // A byte opens a new frame when nothing is counted yet, or when it rides
    // on the same cycle that hands the previous result away.
    assign first     = (cnt == '0) | handshake;
    assign cnt_next  = first ? CNT_W'(1) : cnt + CNT_W'(1);
    assign frame_end = bus.in_last | (cnt_next == FRAME_LEN_C);

    // Adder operands: a fresh frame starts from zero.
    assign bus.add_a = first ? '0 : acc;
    assign bus.add_b = bus.in_data;

`ifdef ADDER4_ACC_SAT_EN
    logic sat;
    logic carry;
    logic sat_hit;

    // Carry out of the 8-bit add, recovered from the operand and sum MSBs.
    assign carry   = (bus.add_a[7] & bus.add_b[7]) |
                     ((bus.add_a[7] ^ bus.add_b[7]) & ~bus.add_sum[7]);
    // Once saturated the frame stays pinned at all-ones; a fresh frame has
    // add_a = 0 so it can never carry on its first byte.
    assign sat_hit = (~first & sat) | carry;
    assign acc_next = sat_hit ? {DATA_W{1'b1}} : bus.add_sum;
    assign bus.out_sat = in_hold & sat;
`else
    assign acc_next = bus.add_sum;
    assign bus.out_sat = 1'b0;
`endif

    // State, accumulator, counter and saturation flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
`ifdef ADDER4_ACC_SAT_EN
            sat   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                // In HOLD an accept can only happen together with the handshake.
                acc   <= acc_next;
                cnt   <= cnt_next;
`ifdef ADDER4_ACC_SAT_EN
                sat   <= sat_hit;
`endif
                state <= frame_end ? HOLD : ACCUM;
            end else if (handshake) begin
                cnt   <= '0;
                state <= IDLE;
            end
        end
    end

    // Output decode; only in_ready in HOLD passes out_ready straight through.
    assign bus.in_ready  = in_hold ? bus.out_ready : 1'b1;
    assign bus.out_valid = in_hold;
    assign bus.out_data  = in_hold ? acc : '0;
    assign bus.out_count = in_hold ? cnt : '0;
    assign busy          = (state == ACCUM);

endmodule

// File: tb/tb_adder4_acc_ctrl.sv
// tb_adder4_acc_ctrl: scoreboard bench for two accumulator instances
// (FRAME_LEN = 4 and FRAME_LEN = 1), each driving a behavioural adder.
module tb_adder4_acc_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] count;
        logic       sat;
    } res_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 wb_clk_i = ~wb_clk_i;

    adder4_acc_ctrl_if i4 ();
    adder4_acc_ctrl_if i1 ();
    logic busy4;
    logic busy1;

    logic       v [2];
    logic       l [2];
    logic       o [2];
    logic [7:0] b [2];

    assign i4.in_valid  = v[0];
    assign i4.in_last   = l[0];
    assign i4.in_data   = b[0];
    assign i4.out_ready = o[0];
    assign i1.in_valid  = v[1];
    assign i1.in_last   = l[1];
    assign i1.in_data   = b[1];
    assign i1.out_ready = o[1];

    // Behavioural adder: plain modulo-256 addition.
    assign i4.add_sum = i4.add_a + i4.add_b;
    assign i1.add_sum = i1.add_a + i1.add_b;

    adder4_acc_ctrl #(.FRAME_LEN(4)) dut4 (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (i4),
        .busy     (busy4)
    );

    adder4_acc_ctrl #(.FRAME_LEN(1)) dut1 (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (i1),
        .busy     (busy1)
    );

    int   errors = 0;
    int   checks = 0;
    int   fsum [2];
    int   fcnt [2];
    bit   hold [2];
    bit   rdy_s [2];
    res_t exp4 [$];
    res_t exp1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of accepted bytes; its result
    // is their true sum, wrapped or clamped, together with how many there were.
    task automatic step(input int d);
        int   flen;
        res_t r;
        flen = (d == 0) ? 4 : 1;
        if (hold[d] && o[d] === 1'b1) hold[d] = 1'b0;
        if (v[d] === 1'b1 && rdy_s[d]) begin
            fsum[d] += int'(b[d]);
            fcnt[d] += 1;
            if (l[d] === 1'b1 || fcnt[d] == flen) begin
`ifdef ADDER4_ACC_SAT_EN
                r.data = (fsum[d] > 255) ? 8'hFF : 8'(fsum[d]);
                r.sat  = (fsum[d] > 255);
`else
                r.data = 8'(fsum[d] % 256);
                r.sat  = 1'b0;
`endif
                r.count = 8'(fcnt[d]);
                if (d == 0) exp4.push_back(r);
                else        exp1.push_back(r);
                hold[d] = 1'b1;
                fsum[d] = 0;
                fcnt[d] = 0;
            end
        end
    endtask

    always @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            step(0);
            step(1);
        end
    end

    task automatic mon(input int d, input logic ov, input logic ir, input logic [7:0] od,
                       input logic [7:0] oc, input logic os, input logic bz, input logic [7:0] ab);
        res_t e;
        string s;
        s = (d == 0) ? "4" : "1";
        chk({"out_valid", s}, 32'(ov), 32'(hold[d]));
        chk({"in_ready", s}, 32'(ir), 32'(!hold[d] || o[d] === 1'b1));
        chk({"busy", s}, 32'(bz), 32'(!hold[d] && fcnt[d] > 0));
        chk({"add_b", s}, 32'(ab), 32'(b[d]));
        if (ov === 1'b1 && o[d] === 1'b1) begin
            checks++;
            if ((d == 0 && exp4.size() == 0) || (d == 1 && exp1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_result%s: got data %0h with empty scoreboard", s, od);
            end else begin
                e = (d == 0) ? exp4.pop_front() : exp1.pop_front();
                chk({"out_data", s}, 32'(od), 32'(e.data));
                chk({"out_count", s}, 32'(oc), 32'(e.count));
                chk({"out_sat", s}, 32'(os), 32'(e.sat));
            end
        end
    endtask

    // Monitor: sample away from the active edge and check against the model.
    always @(negedge wb_clk_i) begin
        rdy_s[0] = (i4.in_ready === 1'b1);
        rdy_s[1] = (i1.in_ready === 1'b1);
        if (!wb_rst_i) begin
            mon(0, i4.out_valid, i4.in_ready, i4.out_data, i4.out_count, i4.out_sat, busy4, i4.add_b);
            mon(1, i1.out_valid, i1.in_ready, i1.out_data, i1.out_count, i1.out_sat, busy1, i1.add_b);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #2;
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic last);
        int n;
        n = 0;
        v[d] = 1'b1;
        b[d] = data;
        l[d] = last;
        do begin
            @(posedge wb_clk_i);
            n++;
        end while (!rdy_s[d] && n < 64);
        #2;
        chk("send_accept_in_time", 32'(rdy_s[d]), 32'd1);
        v[d] = 1'b0;
        l[d] = 1'b0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            hold[d] = 1'b0;
            fsum[d] = 0;
            fcnt[d] = 0;
        end
        exp4.delete();
        exp1.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(i4.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(i4.out_data), 32'd0);
        chk({tag, "_out_count"}, 32'(i4.out_count), 32'd0);
        chk({tag, "_out_sat"}, 32'(i4.out_sat), 32'd0);
        chk({tag, "_busy"}, 32'(busy4), 32'd0);
        chk({tag, "_in_ready"}, 32'(i4.in_ready), 32'd1);
        chk({tag, "_add_a"}, 32'(i4.add_a), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0;
            l[d] = 1'b0;
            o[d] = 1'b1;
            b[d] = 8'h00;
        end
        clear_model();
        #1;
        chk_reset_outputs("reset");
        tick(2);
        wb_rst_i = 1'b0;
        tick(1);

        // Full frame, result held by the consumer.
        o[0] = 1'b0;
        send(0, 8'h10, 1'b0);
        send(0, 8'h20, 1'b0);
        send(0, 8'h30, 1'b0);
        send(0, 8'h40, 1'b0);
        chk("frame4_valid", 32'(i4.out_valid), 32'd1);
        chk("frame4_data", 32'(i4.out_data), 32'hA0);
        chk("frame4_count", 32'(i4.out_count), 32'd4);
        chk("frame4_busy", 32'(busy4), 32'd0);

        // Backpressure with a byte on offer, then simultaneous transfer.
        v[0] = 1'b1;
        b[0] = 8'h11;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(i4.in_ready), 32'd0);
            chk("bp_data_stable", 32'(i4.out_data), 32'hA0);
            chk("bp_count_stable", 32'(i4.out_count), 32'd4);
            tick(1);
        end
        o[0] = 1'b1;
        tick(1);
        v[0] = 1'b0;
        chk("bp_next_valid", 32'(i4.out_valid), 32'd0);
        chk("bp_next_busy", 32'(busy4), 32'd1);
        chk("bp_next_acc", 32'(i4.add_a), 32'h11);
        send(0, 8'h01, 1'b0);
        send(0, 8'h02, 1'b0);
        send(0, 8'h03, 1'b0);
        chk("bp_frame_data", 32'(i4.out_data), 32'h17);

        // Overflowing frame.
        send(0, 8'h80, 1'b0);
        send(0, 8'h90, 1'b0);
        send(0, 8'h01, 1'b0);
        send(0, 8'h02, 1'b0);
`ifdef ADDER4_ACC_SAT_EN
        chk("ovf_data", 32'(i4.out_data), 32'hFF);
        chk("ovf_sat", 32'(i4.out_sat), 32'd1);
`else
        chk("ovf_data", 32'(i4.out_data), 32'h13);
        chk("ovf_sat", 32'(i4.out_sat), 32'd0);
`endif

        // Early end via in_last, back-to-back with the previous result.
        send(0, 8'h05, 1'b0);
        send(0, 8'h07, 1'b1);
        chk("last_valid", 32'(i4.out_valid), 32'd1);
        chk("last_data", 32'(i4.out_data), 32'h0C);
        chk("last_count", 32'(i4.out_count), 32'd2);
        tick(1);

        // Reset in the middle of a frame.
        send(0, 8'hAB, 1'b0);
        send(0, 8'hCD, 1'b0);
        chk("pre_reset_busy", 32'(busy4), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        clear_model();
        chk_reset_outputs("midreset");
        tick(2);
        wb_rst_i = 1'b0;
        tick(1);
        send(0, 8'h01, 1'b0);
        send(0, 8'h01, 1'b0);
        send(0, 8'h01, 1'b0);
        send(0, 8'h01, 1'b0);
        chk("post_reset_data", 32'(i4.out_data), 32'h04);
        chk("post_reset_count", 32'(i4.out_count), 32'd4);
        tick(1);

        // Single-byte frames, consumer always ready.
        send(1, 8'hAA, 1'b0);
        chk("len1_first_valid", 32'(i1.out_valid), 32'd1);
        chk("len1_first_data", 32'(i1.out_data), 32'hAA);
        chk("len1_first_count", 32'(i1.out_count), 32'd1);
        send(1, 8'h55, 1'b0);
        chk("len1_second_valid", 32'(i1.out_valid), 32'd1);
        chk("len1_second_data", 32'(i1.out_data), 32'h55);
        chk("len1_second_count", 32'(i1.out_count), 32'd1);
        tick(2);

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                v[d] = 1'($urandom_range(0, 1));
                b[d] = 8'($urandom);
                l[d] = ($urandom_range(0, 5) == 0);
                o[d] = ($urandom_range(0, 3) != 0);
            end
            tick(1);
        end

        // Drain.
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0;
            l[d] = 1'b0;
            o[d] = 1'b1;
        end
        tick(4);
        chk("drain_scoreboard4", 32'(exp4.size()), 32'd0);
        chk("drain_scoreboard1", 32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
